// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes common with the ALU control decoder,
// execute-stage FSM states and op classification helpers.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'h0,
        ALU_OR   = 4'h1,
        ALU_ADD  = 4'h2,
        ALU_SLL  = 4'h3,
        ALU_SRL  = 4'h4,
        ALU_SUB  = 4'h6,
        ALU_SLT  = 4'h7,
        ALU_ADDU = 4'h8,
        ALU_SUBU = 4'h9,
        ALU_XOR  = 4'hA,
        ALU_SLTU = 4'hB,
        ALU_NOR  = 4'hC,
        ALU_SRA  = 4'hD,
        ALU_LUI  = 4'hE
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    function automatic logic is_shift(input logic [3:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_core.sv
// Single-cycle ALU operations (logic, add/sub with signed overflow, compares, LUI).
// Shift codes and undefined codes produce zero here; shifts are handled iteratively by alu_exec.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             ovf
);

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;

    assign sum_s  = a + b;
    assign diff_s = a - b;

    // Select the operation result; overflow only meaningful for signed ADD/SUB
    always_comb begin
        res = {WIDTH{1'b0}};
        ovf = 1'b0;
        case (ctrl)
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
            ALU_NOR:  res = ~(a | b);
            ALU_ADD: begin
                res = sum_s;
                ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                res = diff_s;
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_ADDU: res = sum_s;
            ALU_SUBU: res = diff_s;
            ALU_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_LUI:  res = {b[15:0], {(WIDTH-16){1'b0}}};
            default: begin
                res = {WIDTH{1'b0}};
                ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with valid/ready handshake, registered result/flags and a
// 1-bit-per-cycle iterative shifter for SLL/SRL/SRA.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_ctrl,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               overflow
);

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    alu_state_t         state_r, state_nxt_s;
    logic [3:0]         op_r;
    logic [WIDTH-1:0]   acc_r;
    logic [SHAMT_W-1:0] cnt_r;
    logic [WIDTH-1:0]   result_r;
    logic               zero_r;
    logic               overflow_r;
    logic               out_valid_r;
    logic               accept_s;
    logic               last_shift_s;
    logic [WIDTH-1:0]   core_res_s;
    logic               core_ovf_s;
    logic [WIDTH-1:0]   shift_step_s;

    assign in_ready     = (state_r == IDLE);
    assign accept_s     = in_valid && in_ready;
    assign last_shift_s = (cnt_r == CNT_ONE);
    assign out_valid    = out_valid_r;
    assign result       = result_r;
    assign zero         = zero_r;
    assign overflow     = overflow_r;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .ctrl (alu_ctrl),
        .a    (a),
        .b    (b),
        .res  (core_res_s),
        .ovf  (core_ovf_s)
    );

    // Next-state logic; DONE never accepts, so the issue interval is at least 2 cycles
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (is_shift(alu_ctrl) && (shamt != {SHAMT_W{1'b0}})) begin
                        state_nxt_s = SHIFT;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_shift_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // One-bit shift of the accumulator in the direction of the latched op
    always_comb begin
        shift_step_s = acc_r;
        case (op_r)
            ALU_SLL: shift_step_s = {acc_r[WIDTH-2:0], 1'b0};
            ALU_SRL: shift_step_s = {1'b0, acc_r[WIDTH-1:1]};
            ALU_SRA: shift_step_s = {acc_r[WIDTH-1], acc_r[WIDTH-1:1]};
            default: shift_step_s = acc_r;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, shift iteration and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_r        <= 4'h0;
            acc_r       <= {WIDTH{1'b0}};
            cnt_r       <= {SHAMT_W{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            overflow_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= (state_nxt_s == DONE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r <= alu_ctrl;
                        if (is_shift(alu_ctrl)) begin
                            acc_r <= b;
                            cnt_r <= shamt;
                            if (shamt == {SHAMT_W{1'b0}}) begin
                                result_r   <= b;
                                zero_r     <= (b == {WIDTH{1'b0}});
                                overflow_r <= 1'b0;
                            end
                        end else begin
                            result_r   <= core_res_s;
                            zero_r     <= (core_res_s == {WIDTH{1'b0}});
                            overflow_r <= core_ovf_s;
                        end
                    end
                end
                SHIFT: begin
                    acc_r <= shift_step_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (last_shift_s) begin
                        result_r   <= shift_step_s;
                        zero_r     <= (shift_step_s == {WIDTH{1'b0}});
                        overflow_r <= 1'b0;
                    end
                end
                default: begin
                    op_r <= op_r;
                end
            endcase
        end
    end

endmodule
